// File: rtl/gf2m_pkg.sv
// rtl/gf2m_pkg.sv - shared types and defaults for the GF(2^m) reduction stage
package gf2m_pkg;

  // Default geometry for the supported curve: f(x) = x^127 + x + 1
  localparam int           DEF_PROD_W = 256;
  localparam int           DEF_M      = 127;
  localparam logic [126:0] DEF_POLY   = 127'h3;

  // Fold counter width; the counter saturates at its all-ones value
  localparam int           FOLD_CNT_W = 8;

  // Reduction controller states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FOLD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/gf2_const_fold.sv
// rtl/gf2_const_fold.sv - one combinational fold of r modulo x^M + g(x)
module gf2_const_fold
  import gf2m_pkg::*;
#(
  parameter int         PROD_W = DEF_PROD_W,
  parameter int         M      = DEF_M,
  parameter logic [M-1:0] POLY = DEF_POLY
) (
  input  logic [PROD_W-1:0] r,
  output logic [PROD_W-1:0] r_fold
);

  // Part of r above degree M-1, right-aligned but kept at full width so the
  // shifted copies below truncate naturally at PROD_W bits.
  logic [PROD_W-1:0] hi_ext;
  logic [PROD_W-1:0] t;

  assign hi_ext = r >> M;

  // Replace x^M by g(x): XOR one shifted copy of hi per set bit of g
  always_comb begin
    t = '0;
    for (int i = 0; i < M; i++) begin
      if (POLY[i]) begin
        t = t ^ (hi_ext << i);
      end
    end
  end

  // Low M bits pass through, high part is replaced by its g(x) image
  assign r_fold = {{(PROD_W-M){1'b0}}, r[M-1:0]} ^ t;

endmodule

// File: rtl/gf2m_reduce_module.sv
// rtl/gf2m_reduce_module.sv - iterative modular reduction of a carry-less product
module gf2m_reduce_module
  import gf2m_pkg::*;
#(
  parameter int           PROD_W = DEF_PROD_W,
  parameter int           M      = DEF_M,
  parameter logic [M-1:0] POLY   = DEF_POLY
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  prod_valid,
  input  logic [PROD_W-1:0]     prod_in,
  output logic                  ready,
  output logic                  Out_Busy,
  output logic [M-1:0]          red_out,
  output logic                  red_valid,
  output logic [FOLD_CNT_W-1:0] fold_cnt,
  output logic                  overrun
);

  state_t            state;
  state_t            state_nxt;
  logic [PROD_W-1:0] r;
  logic [PROD_W-1:0] r_fold;
  logic              reduced;
  logic              accept;
  logic              do_fold;
  logic              finish;

  gf2_const_fold #(
    .PROD_W (PROD_W),
    .M      (M),
    .POLY   (POLY)
  ) u_fold (
    .r      (r),
    .r_fold (r_fold)
  );

  // Nothing left above degree M-1 means r is already the field element
  assign reduced = ~|r[PROD_W-1:M];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, handshake outputs and datapath controls
  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    Out_Busy  = 1'b0;
    accept    = 1'b0;
    do_fold   = 1'b0;
    finish    = 1'b0;
    case (state)
      ST_IDLE: begin
        ready = 1'b1;
        if (prod_valid) begin
          accept    = 1'b1;
          state_nxt = ST_FOLD;
        end
      end
      ST_FOLD: begin
        Out_Busy = 1'b1;
        if (reduced) begin
          finish    = 1'b1;
          state_nxt = ST_DONE;
        end else begin
          do_fold = 1'b1;
        end
      end
      ST_DONE: begin
        // Accepting here keeps back-to-back operations bubble-free
        ready = 1'b1;
        if (prod_valid) begin
          accept    = 1'b1;
          state_nxt = ST_FOLD;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Working register, result, fold counter and sticky overrun flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r         <= '0;
      red_out   <= '0;
      red_valid <= 1'b0;
      fold_cnt  <= '0;
      overrun   <= 1'b0;
    end else begin
      red_valid <= finish;
      if (accept) begin
        r        <= prod_in;
        fold_cnt <= '0;
      end else if (do_fold) begin
        r <= r_fold;
        if (fold_cnt != {FOLD_CNT_W{1'b1}}) begin
          fold_cnt <= fold_cnt + 1'b1;
        end
      end
      if (finish) begin
        red_out <= r[M-1:0];
      end
      // A strobe while busy is dropped; only the flag records it
      if (prod_valid && !ready) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_gf2m_reduce_module.sv
// tb/tb_gf2m_reduce_module.sv - directed self-checking bench for gf2m_reduce_module
module tb_gf2m_reduce_module;

  logic         clk;
  logic         rst_n;
  logic         prod_valid;
  logic [255:0] prod_in;
  logic         ready;
  logic         out_busy;
  logic [126:0] red_out;
  logic         red_valid;
  logic [7:0]   fold_cnt;
  logic         overrun;

  int n_vec = 0;
  int n_bad = 0;

  gf2m_reduce_module dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .prod_valid (prod_valid),
    .prod_in    (prod_in),
    .ready      (ready),
    .Out_Busy   (out_busy),
    .red_out    (red_out),
    .red_valid  (red_valid),
    .fold_cnt   (fold_cnt),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] xpow(input int n);
    logic [255:0] v;
    v = '0;
    v[n] = 1'b1;
    return v;
  endfunction

  // Called at a falling edge; accepts one product and checks latency and result
  task automatic run_op(input string tag, input logic [255:0] val,
                        input logic [126:0] exp_out, input int exp_folds);
    int n;
    prod_valid = 1'b1;
    prod_in    = val;
    @(negedge clk);
    prod_valid = 1'b0;
    n = 1;
    while (!red_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, n, exp_folds + 2);
    check({tag, "_out"}, red_out, exp_out);
    check({tag, "_folds"}, fold_cnt, exp_folds);
    check({tag, "_ready"}, ready, 1'b1);
    check({tag, "_busy"}, out_busy, 1'b0);
    @(negedge clk);
    check({tag, "_valid_drop"}, red_valid, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int n;
    int pulses;
    rst_n      = 1'b0;
    prod_valid = 1'b0;
    prod_in    = '0;
    repeat (2) @(negedge clk);
    check("rst_red_out", red_out, 0);
    check("rst_red_valid", red_valid, 0);
    check("rst_fold_cnt", fold_cnt, 0);
    check("rst_overrun", overrun, 0);
    check("rst_ready", ready, 1);
    check("rst_busy", out_busy, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Already reduced, single fold, two folds, and two more degree patterns
    run_op("one", 256'h1, 127'h1, 0);
    run_op("x127", xpow(127), 127'h3, 1);
    run_op("x254", xpow(254), 127'h5, 2);
    run_op("x255", xpow(255), 127'ha, 2);
    run_op("x253", xpow(253), 127'h4000_0000_0000_0000_0000_0000_0000_0003, 2);
    check("no_overrun_yet", overrun, 0);

    // Strobe while folding: dropped, flagged, original result intact
    prod_valid = 1'b1;
    prod_in    = xpow(254);
    @(negedge clk);
    check("ovr_busy", out_busy, 1);
    prod_in = 256'h1;
    @(negedge clk);
    prod_valid = 1'b0;
    check("ovr_set", overrun, 1);
    n = 0;
    while (!red_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("ovr_out", red_out, 127'h5);
    check("ovr_folds", fold_cnt, 2);
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (red_valid) pulses++;
    end
    check("ovr_no_second", pulses, 0);
    check("ovr_sticky", overrun, 1);
    check("ovr_out_hold", red_out, 127'h5);
    do_reset();
    check("ovr_cleared", overrun, 0);

    // Back-to-back: accept in the DONE cycle of x^127
    prod_valid = 1'b1;
    prod_in    = xpow(127);
    @(negedge clk);
    prod_valid = 1'b0;
    n = 0;
    while (!red_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("b2b_first_out", red_out, 127'h3);
    check("b2b_done_ready", ready, 1);
    prod_valid = 1'b1;
    prod_in    = 256'h1;
    @(negedge clk);
    prod_valid = 1'b0;
    check("b2b_fold_busy", out_busy, 1);
    check("b2b_fold_valid", red_valid, 0);
    @(negedge clk);
    check("b2b_second_valid", red_valid, 1);
    check("b2b_second_out", red_out, 127'h1);
    check("b2b_second_folds", fold_cnt, 0);
    check("b2b_overrun", overrun, 0);
    @(negedge clk);

    // Asynchronous reset in the middle of the second fold of x^254
    prod_valid = 1'b1;
    prod_in    = xpow(254);
    @(negedge clk);
    prod_valid = 1'b0;
    @(negedge clk);
    check("mid_folds", fold_cnt, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_red_out", red_out, 0);
    check("async_red_valid", red_valid, 0);
    check("async_fold_cnt", fold_cnt, 0);
    check("async_ready", ready, 1);
    check("async_busy", out_busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", ready, 1);
    run_op("post_rst_x127", xpow(127), 127'h3, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
